// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers between CPU stages.
// Holds the stage occupancy states, the default bubble control value and
// the control-field widths/positions used by the stage instances.
package pipe_pkg;

    // Occupancy state of a stage register; the encoding equals the entry count.
    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_ONE   = 2'd1;
    localparam pipe_state_t ST_TWO   = 2'd2;

    // Full control word width carried out of decode.
    localparam int unsigned CTRL_W_CPU = 8;

    // Control value for an empty slot: every enable deasserted.
    localparam logic [CTRL_W_CPU-1:0] BUBBLE_CTRL_DEFAULT = '0;

    // Bit positions inside the decode control word.
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_BRANCH     = 2;
    localparam int unsigned CTRL_MEM_READ   = 3;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_ALU_SRC    = 5;
    localparam int unsigned CTRL_ALU_OP_LSB = 6;
    localparam int unsigned CTRL_ALU_OP_W   = 2;

    // Control widths left at each boundary as fields are consumed.
    localparam int unsigned CTRL_W_IFID  = 0;
    localparam int unsigned CTRL_W_IDEX  = CTRL_W_CPU;
    localparam int unsigned CTRL_W_EXMEM = 5;
    localparam int unsigned CTRL_W_MEMWB = 2;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_count(input pipe_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ST_EMPTY: n = 2'd0;
            ST_ONE:   n = 2'd1;
            ST_TWO:   n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of a pipeline stage: a W-bit register with load enable
// and asynchronous active-high clear.
module pipe_entry #(
    parameter int unsigned W = 40
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Capture d_i when loaded; cleared immediately by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline stage register carrying a data word and a
// control word between adjacent CPU stages, with stall and flush support.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready_o is registered
// and has no combinational dependence on out_ready_i.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        count_o
);

    localparam int unsigned ENTRY_W = DATA_W + CTRL_W;

    pipe_state_t        state_q;
    pipe_state_t        state_d;
    logic               out_valid;
    logic               in_xfer;
    logic               out_xfer;
    logic               main_load;
    logic [ENTRY_W-1:0] main_d;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] in_entry;

    assign in_entry  = {in_data_i, in_ctrl_i};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid_i & in_ready_o & start_i;
    assign out_xfer  = out_valid & out_ready_i & start_i;

`ifdef PIPE_STAGE_SKID_EN

    logic               skid_load;
    logic [ENTRY_W-1:0] skid_q;
    logic               in_ready_q;
    logic               in_ready_d;

    // Next state and register loads for the two-entry stage.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_d    = in_entry;
        skid_load = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    // Head is stalled: park the new entry behind it.
                    state_d   = ST_TWO;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush drops everything; main keeps its data so out_data_o holds.
        if (flush_i) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    assign in_ready_d = (state_d != ST_TWO);

    // Registered ready, derived from the next occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o = in_ready_q;

    pipe_entry #(
        .W (ENTRY_W)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (skid_load),
        .d_i    (in_entry),
        .q_o    (skid_q)
    );

`else

    // Single entry: accept whenever the slot is free or drains this cycle.
    assign in_ready_o = ~out_valid | out_ready_i;

    // Next state and main load for the single-entry stage.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_d    = in_entry;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush_i) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
        end
    end

`endif

    // Occupancy state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry #(
        .W (ENTRY_W)
    ) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    assign out_valid_o = out_valid;
    assign out_data_o  = main_q[ENTRY_W-1:CTRL_W];
    assign out_ctrl_o  = out_valid ? main_q[CTRL_W-1:0] : BUBBLE_CTRL;
    assign count_o     = state_count(state_q);

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register replacing the fixed-field IFID/IDEX/EXMEM/MEMWB registers in the CPU datapath. It carries a generic data word and a control word between adjacent stages using a valid/ready handshake. It supports stall through backpressure and flush through a bubble insert, and can optionally add a skid entry so that `in_ready_o` is registered. One instance sits at each stage boundary.

## Interface
Parameters:
- DATA_W, 32, width of the payload word (PC, operands, immediates concatenated by the instantiator)
- CTRL_W, 8, width of the control word (RegWrite, MemtoReg, Branch, MemRead, MemWrite, ...)
- BUBBLE_CTRL, '0, control value driven whenever the output is not valid

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  run enable; while low, no transfer is accepted and the stored state holds
- flush_i  in  1  synchronous flush; discards every held entry
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept an entry this cycle
- in_data_i  in  DATA_W  upstream payload
- in_ctrl_i  in  CTRL_W  upstream control
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  downstream accepts the output this cycle
- out_data_o  out  DATA_W  head payload
- out_ctrl_o  out  CTRL_W  head control; BUBBLE_CTRL when out_valid_o=0
- count_o  out  2  entries held (0..2)

## Operation
- An input transfer occurs when in_valid_i & in_ready_o & start_i. An output transfer occurs when out_valid_o & out_ready_i & start_i.
- Entries leave in order; no entry is duplicated or reordered.
- States: EMPTY (0 entries), ONE (main register valid), TWO (main and skid registers valid; only with the skid feature).
- Transitions:
  - EMPTY: on input -> ONE.
  - ONE: input only -> TWO, or overwrite main if the skid feature is off (see Configuration). Output only -> EMPTY. Both -> ONE with the new entry.
  - TWO: output -> ONE, with skid moved to main. No input is possible in TWO.
- flush_i=1: next state is EMPTY, regardless of any in or out transfer in that cycle. An input presented in the flush cycle is dropped. An output handshake in the flush cycle still counts as consumed downstream.
- flush_i is honoured even when start_i=0.
- When out_valid_o=0, out_ctrl_o=BUBBLE_CTRL and out_data_o holds its last value.

## Timing
- Reset values: out_valid_o=0, out_ctrl_o=BUBBLE_CTRL, out_data_o=0, count_o=0, state EMPTY, in_ready_o=1 (skid on) or the combinational value (skid off).
- Latency: 1 cycle. An entry accepted at edge N appears on the outputs after edge N.
- Full throughput: one entry per cycle while out_ready_i stays high.
- Stall: with out_ready_i=0, the head and its control hold stable until accepted.
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two-entry storage.
  - in_ready_o is a register output, equal to (state != TWO) and to 1 in EMPTY/ONE.
  - No combinational path from out_ready_i to in_ready_o.
- Not defined:
  - Single entry.
  - in_ready_o = ~out_valid_o | out_ready_i, which is combinational.
  - State TWO is unreachable and count_o never exceeds 1.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, ONE, TWO)
  - the default bubble constant
  - the CPU-level control-field width constants used by the stage instances
- One sub-module, pipe_entry: a DATA_W+CTRL_W register with a load enable and an asynchronous clear. It is instantiated as the main register and, under the macro, as the skid register.

## Test plan
- Reset then stream: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready_i=1. Outputs show 0x11, 0x22, 0x33 one cycle later, back-to-back, with count_o=1 throughout.
- Backpressure (skid on): out_ready_i=0, push 0xA and 0xB.
  - count_o=2 and in_ready_o=0 the cycle after 0xB.
  - Raise out_ready_i: 0xA then 0xB emerge, and in_ready_o returns to 1 after the first pop.
- Flush while full: hold 2 entries, assert flush_i together with in_valid_i=1 and data 0xC. Next cycle out_valid_o=0, out_ctrl_o=BUBBLE_CTRL, count_o=0, and 0xC never appears.
- Bubble control: BUBBLE_CTRL=8'h00 with in_ctrl_i=8'hFF, no valid input. out_ctrl_o stays 8'h00.
- Asynchronous reset mid-stall: assert rst_i between edges with 2 entries held. out_valid_o falls before the next edge.
- start_i=0: in_valid_i=1 with data 0x5 produces no transfer and count_o holds. Raising start_i accepts 0x5.
